ascii_rom_arbiter: RTL
======================

ASCII_ROM_ARBITER -- requirements
Module: ascii_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of text requesters sharing one ascii_rom (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 11: ROM address width, {char_addr[6:0], row_addr[3:0]}.
REQ-003 SHALL have parameter DATA_W, default 8: ROM word width, one glyph row.
REQ-004 SHALL have port clk  input  1  system pixel clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester lookup request; bit i for requester i.
REQ-007 SHALL have port addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot (or zero) grant, combinational, same cycle as req.
REQ-009 SHALL have port rom_addr  output  ADDR_W  address driven to the shared ascii_rom.
REQ-010 SHALL have port rom_data  input  DATA_W  ascii_rom data, registered inside ROM (1-cycle latency).
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  registered one-hot flag: rsp_data belongs to requester i this cycle.
REQ-012 SHALL have port rsp_data  output  DATA_W  glyph row returned; equals rom_data.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt SHALL be zero when req is zero.
REQ-014 SHALL arbitrate round-robin: search starts at pointer ptr, ascending index, wrapping NUM_REQ-1 -> 0; first asserted req wins.
REQ-015 SHALL update ptr on each grant to (granted index + 1) mod NUM_REQ; ptr SHALL hold when no grant.
REQ-016 SHALL drive rom_addr with the granted requester's addr in the grant cycle; with no grant, rom_addr SHALL hold its last driven value (registered copy).
REQ-017 SHALL assert rsp_valid[i] in cycle t+1 exactly when gnt[i] was asserted in cycle t; latency fixed at 1 cycle.
REQ-018 SHALL pass rom_data to rsp_data unmodified; rsp_data is don't-care when rsp_valid is zero.
REQ-019 SHALL sustain one grant per cycle back-to-back, including consecutive grants to different requesters.
REQ-020 A requester not granted SHALL keep req asserted; the arbiter SHALL NOT queue requests (no buffering beyond one response stage).
REQ-021 SHALL guarantee any continuously asserted req is granted within NUM_REQ cycles (round-robin mode).
REQ-022 SHALL treat a change of addr while req held and ungranted as the new request; only the address in the grant cycle is used.

Reset
REQ-023 On reset assertion SHALL immediately force: ptr=0, rsp_valid=0, held rom_addr=0; gnt follows req from ptr=0.
REQ-024 A grant issued in the cycle reset asserts SHALL produce no rsp_valid; response in flight SHALL be discarded.
REQ-025 After reset deassertion, first rising edge SHALL arbitrate normally from ptr=0.

Configuration
REQ-026 Macro ASCII_ARB_PRIO0_EN defined: requester 0 (score text) SHALL win whenever req[0]=1, overriding ptr; ptr SHALL not change on a requester-0 grant; remaining requesters round-robin as REQ-014/015.
REQ-027 Macro ASCII_ARB_PRIO0_EN undefined: pure round-robin over all requesters; REQ-021 bound applies to all.

Verification
REQ-028 Reset, req=3'b000 -> gnt=0, rsp_valid=0, rom_addr=0 held for all cycles.
REQ-029 NUM_REQ=3, req=3'b111 held 6 cycles from reset -> gnt sequence 001,010,100,001,010,100; rsp_valid same sequence delayed 1 cycle.
REQ-030 req=3'b010 with addr1=11'h345 single cycle -> gnt=010, rom_addr=11'h345; next cycle rsp_valid=010, rsp_data=ROM[11'h345]; rom_addr holds 11'h345 after.
REQ-031 Grant to requester 2 in cycle t, reset asserted at t -> rsp_valid=0 at t+1; after release, req=3'b111 -> first gnt=001.
REQ-032 ASCII_ARB_PRIO0_EN defined, req=3'b111 held 4 cycles -> gnt=001 every cycle; drop req[0] -> gnt=010 then 100 alternating.
REQ-033 Undefined macro, req[2] held while req[0],req[1] toggle randomly 1000 cycles -> every gap between req[2] grants <= 3 cycles; never two gnt bits high.

Source files
------------

// File: rtl/ascii_rom_arbiter.sv
// Purpose : round-robin arbiter letting NUM_REQ text requesters share one registered ascii_rom.
// Latency : grant and rom_addr are combinational; rsp_valid/rsp_data arrive 1 cycle after the grant.
// Backpr. : no queuing; a requester that is not granted keeps req high and retries every cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high reset
//   req        per-requester lookup request (bit i = requester i)
//   addr       flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        one-hot (or zero) grant, same cycle as req
//   rom_addr   address to the shared ROM; holds the last granted address when idle
//   rom_data   ROM output (registered inside the ROM, 1-cycle latency)
//   rsp_valid  registered one-hot owner of rsp_data
//   rsp_data   glyph row, passed through from rom_data
//
// Build option: define ASCII_ARB_PRIO0_EN to give requester 0 absolute priority
// (its grants leave the round-robin pointer untouched).

module ascii_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W:0]    cand_sum;
  logic              gnt_any;
  logic              prio_hit;
  logic [ADDR_W-1:0] addr_hold;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  // Unflatten the address bus so the grant index can select it directly.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
  end

  // Winner search: optional requester-0 override, then walk upward from ptr
  // with wrap-around and take the first asserted request.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    prio_hit = 1'b0;
    cand     = '0;
    cand_sum = '0;
`ifdef ASCII_ARB_PRIO0_EN
    if (req[0]) begin
      gnt_any  = 1'b1;
      prio_hit = 1'b1;
    end
`else
    prio_hit = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ and k < NUM_REQ, so one conditional subtract is a full modulo.
      cand_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Idle cycles replay the last granted address so the ROM input stays stable.
  assign rom_addr = gnt_any ? addr_arr[gnt_idx] : addr_hold;
  assign rsp_data = rom_data;

  // Pointer moves past the winner; a priority grant to requester 0 leaves it alone
  // so the other requesters keep their round-robin position.
  always_comb begin
    ptr_next = ptr;
    if (gnt_any && !prio_hit) begin
      if (gnt_idx == PTR_W'(NUM_REQ-1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = gnt_idx + PTR_W'(1);
      end
    end
  end

  // rsp_valid mirrors the ROM's one-cycle read latency. Reset clears it at once,
  // which also drops any response for a grant issued while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      addr_hold <= '0;
      rsp_valid <= '0;
    end else begin
      ptr       <= ptr_next;
      rsp_valid <= gnt;
      if (gnt_any) begin
        addr_hold <= rom_addr;
      end
    end
  end

endmodule
